mcpu_ram_controller: RTL and testbench
======================================

MCPU_RAM_CONTROLLER -- requirements
Module: mcpu_ram_controller

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data/instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 SHALL have parameter RAM_SIZE, default 1<<ADDR_WIDTH, number of words.
REQ-004 SHALL have one clock and one reset; reset is asynchronous, active-high.
REQ-005 clk  input  1  sole clock, rising-edge active.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 we  input  1  data-port write enable.
REQ-008 datawr  input  WORD_SIZE  write data.
REQ-009 re  input  1  data-port read enable.
REQ-010 addr  input  ADDR_WIDTH  data-port address, shared by read and write.
REQ-011 datard  output  WORD_SIZE  registered data-port read data.
REQ-012 instraddr  input  ADDR_WIDTH  instruction-port address.
REQ-013 instrrd  output  WORD_SIZE  registered instruction-port read data.

Function
REQ-014 Storage SHALL be RAM_SIZE words of WORD_SIZE bits, shared by data and instruction ports.
REQ-015 On a rising clk with we=1, mem[addr] SHALL take datawr; with we=0, memory SHALL be unchanged.
REQ-016 On a rising clk with re=1, datard SHALL take mem[addr]: 1-cycle latency.
REQ-017 With re=0, datard SHALL hold its last value indefinitely.
REQ-018 On every rising clk, instrrd SHALL take mem[instraddr] unconditionally: 1-cycle latency.
REQ-019 The instruction port SHALL be read-only and independent of we/re.
REQ-020 we=1 and re=1 in the same cycle SHALL both be legal; the write SHALL always complete.
REQ-021 Same-cycle collision (write address equals addr or instraddr) SHALL follow REQ-030.
REQ-022 Addresses at or above RAM_SIZE (only possible when RAM_SIZE < 2^ADDR_WIDTH) SHALL be handled as follows: writes ignored; reads return 0.
REQ-023 No write SHALL occur while we is X/Z; memory SHALL not be corrupted by an unknown instraddr.
REQ-024 Address 2^ADDR_WIDTH-1 SHALL be a normal location with no wrap side effects.

Reset
REQ-025 While rst=1, datard and instrrd SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 While rst=1, writes SHALL be blocked.
REQ-027 Reset SHALL NOT clear memory contents; data written before reset SHALL remain readable after it.
REQ-028 On the first rising clk after rst falls, normal operation SHALL resume.

Configuration
REQ-029 The write-forwarding feature SHALL be controlled by macro MCPU_RAM_WR_FORWARD_EN.
REQ-030 With MCPU_RAM_WR_FORWARD_EN defined, a same-cycle write/read to one address SHALL return datawr on datard and/or instrrd (write-first). Without the macro, such a read SHALL return the pre-write contents (read-first).

Verification
REQ-031 Write $random to all 256 addresses, then read each with re pulsed for 1 cycle -> datard equals the written word and holds after re drops.
REQ-032 Write 16'h12E3 to addr 8'h05, then set instraddr=8'h05 -> instrrd = 16'h12E3 one cycle later, regardless of re.
REQ-033 re=0 while addr changes -> datard unchanged.
REQ-034 Write 16'hAAAA to addr 8'h10, then write 16'h5555 with re=1 to the same address in one cycle -> datard = 16'hAAAA without the macro, 16'h5555 with it.
REQ-035 Assert rst mid-test between clock edges -> datard = instrrd = 0 at once; after release, reading addr 8'hFF returns its pre-reset value.
REQ-036 Hold we=1 during rst -> target location unchanged after reset.

Source files
------------

// File: rtl/mcpu_ram_controller.sv
// Shared data/instruction RAM with a registered read/write data port and a registered read-only
// instruction port. Define MCPU_RAM_WR_FORWARD_EN for write-first collisions; default is read-first.
module mcpu_ram_controller #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [WORD_SIZE-1:0]  datawr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WORD_SIZE-1:0]  datard,
    input  logic [ADDR_WIDTH-1:0] instraddr,
    output logic [WORD_SIZE-1:0]  instrrd
);
    localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(RAM_SIZE);

    logic [WORD_SIZE-1:0] mem [RAM_SIZE];

    logic                 data_ok, instr_ok, wr_en;
    logic [IDX_W-1:0]     data_idx, instr_idx;
    logic [WORD_SIZE-1:0] data_mem, instr_mem, data_next, instr_next;

    // Addresses beyond the populated range read as zero and swallow writes.
    assign data_ok   = {1'b0, addr} < LIMIT;
    assign instr_ok  = {1'b0, instraddr} < LIMIT;
    assign data_idx  = addr[IDX_W-1:0];
    assign instr_idx = instraddr[IDX_W-1:0];
    assign data_mem  = data_ok  ? mem[data_idx]  : '0;
    assign instr_mem = instr_ok ? mem[instr_idx] : '0;

    // An unknown we evaluates false, so no write is committed for it.
    assign wr_en = we && !rst && data_ok;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[data_idx] <= datawr;
    end

`ifdef MCPU_RAM_WR_FORWARD_EN
    assign data_next  = wr_en ? datawr : data_mem;
    assign instr_next = (wr_en && (instraddr == addr)) ? datawr : instr_mem;
`else
    assign data_next  = data_mem;
    assign instr_next = instr_mem;
`endif

    // Memory contents survive reset; only the output registers clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            datard  <= '0;
            instrrd <= '0;
        end else begin
            if (re)
                datard <= data_next;
            instrrd <= instr_next;
        end
    end

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Directed bench for mcpu_ram_controller: full-array fill/readback, vector table, reset corner cases.
module tb_mcpu_ram_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, re;
    logic [15:0] datawr;
    logic [7:0]  addr, instraddr;
    logic [15:0] datard, instrrd;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] model [256];

    mcpu_ram_controller dut (
        .clk(clk), .rst(rst), .we(we), .datawr(datawr), .re(re), .addr(addr),
        .datard(datard), .instraddr(instraddr), .instrrd(instrrd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, re;
        logic [7:0]  addr;
        logic [15:0] datawr;
        logic [7:0]  instraddr;
        logic        chk_dr, chk_ir;
        logic [15:0] exp_dr, exp_ir;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] a,
                        input logic [15:0] d, input logic [7:0] ia);
        @(negedge clk);
        we = w; re = r; addr = a; datawr = d; instraddr = ia;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] coll_dr, coll_ir;
`ifdef MCPU_RAM_WR_FORWARD_EN
        coll_dr = 16'h5555; coll_ir = 16'h7777;
`else
        coll_dr = 16'hAAAA; coll_ir = 16'hC0DE;
`endif
        //         we    re    addr   datawr    ia     cdr   cir   exp_dr    exp_ir
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 16'h12E3, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 8'h05, 1'b0, 1'b1, 16'h0000, 16'h12E3};
        vecs[2]  = '{1'b0, 1'b1, 8'h05, 16'h0000, 8'h05, 1'b1, 1'b1, 16'h12E3, 16'h12E3};
        vecs[3]  = '{1'b1, 1'b0, 8'h10, 16'hAAAA, 8'h05, 1'b1, 1'b1, 16'h12E3, 16'h12E3};
        vecs[4]  = '{1'b1, 1'b1, 8'h10, 16'h5555, 8'h05, 1'b1, 1'b1, coll_dr,  16'h12E3};
        vecs[5]  = '{1'b0, 1'b1, 8'h10, 16'h0000, 8'h10, 1'b1, 1'b1, 16'h5555, 16'h5555};
        vecs[6]  = '{1'b0, 1'b0, 8'h33, 16'h0000, 8'h10, 1'b1, 1'b1, 16'h5555, 16'h5555};
        vecs[7]  = '{1'b0, 1'b0, 8'h77, 16'h0000, 8'h10, 1'b1, 1'b1, 16'h5555, 16'h5555};
        vecs[8]  = '{1'b1, 1'b0, 8'hFF, 16'hBEEF, 8'h10, 1'b1, 1'b1, 16'h5555, 16'h5555};
        vecs[9]  = '{1'b1, 1'b0, 8'h20, 16'hC0DE, 8'hFF, 1'b1, 1'b1, 16'h5555, 16'hBEEF};
        vecs[10] = '{1'b1, 1'b0, 8'h20, 16'h7777, 8'h20, 1'b1, 1'b1, 16'h5555, coll_ir};
        vecs[11] = '{1'b0, 1'b1, 8'h20, 16'h0000, 8'h20, 1'b1, 1'b1, 16'h7777, 16'h7777};

        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; datawr = '0; instraddr = '0;
        #1;
        check("reset_datard", datard, 16'h0000);
        check("reset_instrrd", instrrd, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Fill every location, then read back with a single-cycle re pulse and check the hold.
        for (int i = 0; i < 256; i++) begin
            model[i] = 16'($urandom);
            step(1'b1, 1'b0, 8'(i), model[i], 8'h00);
        end
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 8'(i), 16'h0000, 8'(i));
            check("fill_read", datard, model[i]);
            check("fill_instr", instrrd, model[i]);
            step(1'b0, 1'b0, 8'(i + 1), 16'h0000, 8'(i));
            check("fill_hold", datard, model[i]);
        end

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].datawr, vecs[i].instraddr);
            if (vecs[i].chk_dr) check($sformatf("vec%0d_datard", i), datard, vecs[i].exp_dr);
            if (vecs[i].chk_ir) check($sformatf("vec%0d_instrrd", i), instrrd, vecs[i].exp_ir);
        end

        // Mid-cycle reset with a write held on addr FF; outputs must clear immediately.
        @(negedge clk);
        we = 1'b1; re = 1'b1; addr = 8'hFF; datawr = 16'h0000; instraddr = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_datard", datard, 16'h0000);
        check("async_rst_instrrd", instrrd, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_datard", datard, 16'h0000);
        check("rst_hold_instrrd", instrrd, 16'h0000);
        @(negedge clk);
        rst = 1'b0; we = 1'b0; re = 1'b1; addr = 8'hFF; instraddr = 8'h05;
        @(posedge clk);
        #1;
        check("post_rst_read_FF", datard, 16'hBEEF);
        check("post_rst_instr_05", instrrd, 16'h12E3);
        step(1'b0, 1'b1, 8'h10, 16'h0000, 8'h20);
        check("post_rst_read_10", datard, 16'h5555);
        check("post_rst_instr_20", instrrd, 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
